// File: rtl/i2s_tx_scheduler.sv
// Frame/slot sequencer for the I2S/TDM serializer: buffers one sample per slot and issues load strobes.
// Optional I2S_SCHED_REPEAT_EN: an underrun resends the last word sent in that slot instead of zeros.
module i2s_tx_scheduler #(
  parameter int NUM_SLOTS = 2,
  parameter int DW        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [NUM_SLOTS-1:0]    ch_valid,
  output logic [NUM_SLOTS-1:0]    ch_ready,
  input  logic [NUM_SLOTS*DW-1:0] ch_data,
  output logic                    ser_load,
  output logic [DW-1:0]           ser_data,
  output logic                    ws,
  output logic                    frame_start,
  output logic                    busy,
  output logic [NUM_SLOTS-1:0]    underrun,
  input  logic                    underrun_clr
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [BW-1:0]          bit_cnt_reg;
  logic [SW-1:0]          slot_cnt_reg;
  logic [SW-1:0]          slot_nxt;
  logic                   active, bit_last, frame_last, drain_exit, load;
  logic [NUM_SLOTS-1:0]   consume;
  logic [NUM_SLOTS-1:0]   valid_reg;
  logic [DW-1:0]          hold_reg [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   underrun_reg;
  logic [DW-1:0]          fallback;
  logic [DW-1:0]          word;
  logic                   ser_load_reg, ws_reg, frame_start_reg;
  logic [DW-1:0]          ser_data_reg;

  assign slot_nxt   = slot_cnt_reg + SW'(1);
  assign active     = (state_reg != IDLE);
  assign bit_last   = (bit_cnt_reg == BW'(DW - 1));
  assign frame_last = (slot_cnt_reg == SW'(NUM_SLOTS - 1));
  // Leaving DRAIN at the end of the last slot must not start another slot.
  assign drain_exit = (state_reg == DRAIN) && !run && bit_last && frame_last;
  assign load       = active && bit_last && !drain_exit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run) state_next = RUN;
      RUN:     if (!run) state_next = DRAIN;
      DRAIN: begin
        if (run)
          state_next = RUN;
        else if (bit_last && frame_last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= BW'(DW - 1);
      slot_cnt_reg <= SW'(NUM_SLOTS - 1);
    end else begin
      state_reg <= state_next;
      if (load) begin
        bit_cnt_reg  <= '0;
        slot_cnt_reg <= slot_nxt;
      end else if (active && !drain_exit) begin
        bit_cnt_reg <= bit_cnt_reg + BW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign consume[gi]  = load && (slot_nxt == SW'(gi));
    assign ch_ready[gi] = !valid_reg[gi] || consume[gi];
  end

  // A write in the consuming cycle wins: the old word leaves, the new one stays valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rst) begin
        valid_reg[i]    <= 1'b0;
        hold_reg[i]     <= '0;
        underrun_reg[i] <= 1'b0;
      end else begin
        if (ch_valid[i] && ch_ready[i]) begin
          hold_reg[i]  <= ch_data[i*DW +: DW];
          valid_reg[i] <= 1'b1;
        end else if (consume[i]) begin
          valid_reg[i] <= 1'b0;
        end
        if (consume[i] && !valid_reg[i])
          underrun_reg[i] <= 1'b1;
        else if (underrun_clr)
          underrun_reg[i] <= 1'b0;
      end
    end
  end

`ifdef I2S_SCHED_REPEAT_EN
  logic [DW-1:0] last_reg [NUM_SLOTS];

  assign fallback = last_reg[slot_nxt];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rst)
        last_reg[i] <= '0;
      else if (consume[i] && valid_reg[i])
        last_reg[i] <= hold_reg[i];
    end
  end
`else
  assign fallback = '0;
`endif

  assign word = valid_reg[slot_nxt] ? hold_reg[slot_nxt] : fallback;

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_load_reg    <= 1'b0;
      ser_data_reg    <= '0;
      ws_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      ser_load_reg    <= load;
      frame_start_reg <= load && (slot_nxt == '0);
      if (load) begin
        ser_data_reg <= word;
        ws_reg       <= slot_nxt[SW-1];
      end
    end
  end

  assign ser_load    = ser_load_reg;
  assign ser_data    = ser_data_reg;
  assign ws          = ws_reg;
  assign frame_start = frame_start_reg;
  assign busy        = active;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Scoreboard bench for i2s_tx_scheduler (stereo, 32-bit): directed scenarios push expected loads, a monitor checks them.
module tb_i2s_tx_scheduler;

  localparam int NS = 2;
  localparam int DW = 32;
`ifdef I2S_SCHED_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic           clk, rst, run, underrun_clr;
  logic [NS-1:0]  ch_valid, ch_ready, underrun;
  logic [NS*DW-1:0] ch_data;
  logic           ser_load, ws, frame_start, busy;
  logic [DW-1:0]  ser_data;

  i2s_tx_scheduler #(.NUM_SLOTS(NS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .ser_load(ser_load), .ser_data(ser_data), .ws(ws),
    .frame_start(frame_start), .busy(busy),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          ws;
    logic          fs;
    logic          gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic w, input logic f, input logic g);
    exp_t e;
    e.data = d; e.ws = w; e.fs = f; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_load();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ser_load) got = 1'b1;
    end
    check("load_seen", got, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ser_load"}, ser_load, 0);
    check({tag, "_ser_data"}, ser_data, 0);
    check({tag, "_ws"}, ws, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_ch_ready"}, ch_ready, 2'b11);
  endtask

  // Monitor: every ser_load must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (frame_start && !ser_load) check("stray_frame_start", frame_start, 0);
      if (ser_load) begin
        check("load_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("load @%0d data=%08h ws=%0b fs=%0b", cyc, ser_data, ws, frame_start);
          check("ser_data", ser_data, e.data);
          check("ws", ws, e.ws);
          check("frame_start", frame_start, e.fs);
          if (e.gap) check("load_period", cyc - last_cyc, DW);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; ch_valid = '0; ch_data = '0; underrun_clr = 1'b0;
    tick(3);
    check_idle("reset");
    rst = 1'b0;
    tick(1);

    // Prefill, continuous feed, then run dropped at the start of slot 0.
    ch_data  = {32'h5A5A_0002, 32'hA5A5_0001};
    ch_valid = 2'b11;
    tick(1);
    check("prefill_ready", ch_ready, 2'b00);
    push(32'hA5A5_0001, 0, 1, 0); push(32'h5A5A_0002, 1, 0, 1);
    push(32'hA5A5_0001, 0, 1, 1); push(32'h5A5A_0002, 1, 0, 1);
    run = 1'b1;
    wait_load(); wait_load(); wait_load();
    run = 1'b0; ch_valid = '0;
    wait_load();
    tick(31);
    check("t1_busy_drain", busy, 1);
    tick(1);
    check("t1_busy_idle", busy, 0);
    check("t1_underrun", underrun, 2'b00);
    check("t1_ready", ch_ready, 2'b10);
    tick(80);
    check("t1_sb_empty", sb.size(), 0);

    // Reset mid-frame with both holding registers full.
    push(32'hA5A5_0001, 0, 1, 0);
    run = 1'b1;
    wait_load();
    tick(5);
    ch_data  = {32'hDEAD_BEEF, 32'h1111_1111};
    ch_valid = 2'b11;
    tick(1);
    ch_valid = '0;
    check("t6_ready_full", ch_ready, 2'b00);
    rst = 1'b1;
    tick(1);
    check_idle("t6_reset");
    run = 1'b0; rst = 1'b0;
    tick(1);

    // Starved run: fallback words and sticky underrun, then clear.
    push('0, 0, 1, 0); push('0, 1, 0, 1);
    run = 1'b1;
    wait_load();
    check("t2_ur_slot0", underrun, 2'b01);
    wait_load();
    check("t2_ur_both", underrun, 2'b11);
    run = 1'b0;
    tick(40);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("t2_ur_clr", underrun, 2'b00);

    // One sample on slot 0 then starvation; run reasserted during DRAIN.
    ch_data  = {32'h0, 32'h1234_5678};
    ch_valid = 2'b01;
    tick(1);
    ch_valid = '0;
    push(32'h1234_5678, 0, 1, 0); push('0, 1, 0, 1);
    push(REP ? 32'h1234_5678 : 32'h0, 0, 1, 1);
    run = 1'b1;
    wait_load();
    check("t3_ur_f1", underrun, 2'b00);
    wait_load();
    check("t3_ur_s1", underrun, 2'b10);
    wait_load();
    check("t3_ur_f2", underrun, 2'b11);
    run = 1'b0;
    tick(10);
    run = 1'b1;
    push('0, 1, 0, 1); push(REP ? 32'h1234_5678 : 32'h0, 0, 1, 1);
    wait_load(); wait_load();
    run = 1'b0;
    push('0, 1, 0, 1);
    wait_load();
    tick(32);
    check("t3_busy", busy, 0);
    check("t3_sb_empty", sb.size(), 0);

    // Slot 1 producer holds a new word through slot 1's load cycle.
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    ch_data  = {32'h0000_00B1, 32'h0000_00A0};
    ch_valid = 2'b11;
    tick(1);
    ch_data  = {32'h0000_00B2, 32'h0};
    ch_valid = 2'b10;
    push(32'h0000_00A0, 0, 1, 0); push(32'h0000_00B1, 1, 0, 1);
    push(REP ? 32'h0000_00A0 : 32'h0, 0, 1, 1); push(32'h0000_00B2, 1, 0, 1);
    push(REP ? 32'h0000_00A0 : 32'h0, 0, 1, 1); push(REP ? 32'h0000_00B2 : 32'h0, 1, 0, 1);
    run = 1'b1;
    wait_load();
    tick(31);
    check("t4_ready_load", ch_ready, 2'b11);
    wait_load();
    check("t4_ready_after", ch_ready, 2'b01);
    ch_valid = '0;
    wait_load();
    check("t4_ur_s0", underrun, 2'b01);
    wait_load();
    check("t4_ur_s1_fresh", underrun, 2'b01);
    wait_load();
    run = 1'b0;
    wait_load();
    check("t4_ur_s1_dup", underrun, 2'b11);
    tick(32);
    check("t4_busy", busy, 0);
    check("t4_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
